// File: rtl/video_test_gen_pkg.sv
// Shared types and cell-packing helpers for the video test-pattern generator.
package video_test_gen_pkg;

  typedef enum logic [1:0] {
    TEST_MSG   = 2'd0,
    TEST_FILL  = 2'd1,
    TEST_CLEAR = 2'd2,
    TEST_BARS  = 2'd3
  } test_mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } gen_state_t;

  localparam int DISP_ADDR_W = 12;

  typedef logic [3:0]             color_t;
  typedef logic [DISP_ADDR_W-1:0] disp_addr_t;
  typedef logic [15:0]            disp_data_t;

  // A foreground equal to the background would be invisible; nudge it.
  function automatic color_t avoid_fore(input color_t fore, input color_t back);
    color_t res;
    if (fore == back) begin
      res = fore + 4'd5;
    end else begin
      res = fore;
    end
    return res;
  endfunction

  // Display cell layout: {back, fore, char}.
  function automatic disp_data_t pack_cell(input color_t back, input color_t fore,
                                           input logic [7:0] ch);
    return {back, fore, ch};
  endfunction

endpackage

// File: rtl/video_test_gen_if.sv
// Display-memory write port with valid/ready handshake.
interface video_test_gen_if;
  import video_test_gen_pkg::*;

  logic       wr_en;
  logic       wr_ready;
  disp_addr_t wr_addr;
  disp_data_t wr_data;

  modport master (output wr_en, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_en, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/video_test_delay.sv
// Counts end-of-frame pulses and emits a one-cycle trigger every DELAY_FRAMES frames.
module video_test_delay #(
  parameter int DELAY_FRAMES = 300
) (
  input  logic clk,
  input  logic reset,
  input  logic eof_i,
  output logic trig_o
);

  localparam int CW = (DELAY_FRAMES > 1) ? $clog2(DELAY_FRAMES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DELAY_FRAMES - 1);

  logic [CW-1:0] count_q, count_d;
  logic          trig_q, trig_d;

  // Advance the frame count; the wrapping frame schedules a trigger for the next cycle.
  always_comb begin
    count_d = count_q;
    trig_d  = 1'b0;
    if (eof_i) begin
      if (count_q == LAST) begin
        count_d = '0;
        trig_d  = 1'b1;
      end else begin
        count_d = count_q + CW'(1);
      end
    end else begin
      count_d = count_q;
    end
  end

  // Frame counter and trigger registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      trig_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      trig_q  <= trig_d;
    end
  end

  assign trig_o = trig_q;

endmodule

// File: rtl/video_test_gen.sv
// Test-pattern writer: message, fill, clear and colour bars into display memory.
module video_test_gen
  import video_test_gen_pkg::*;
#(
  parameter int                     COLS         = 80,
  parameter int                     ROWS         = 30,
  parameter int                     DELAY_FRAMES = 300,
  parameter int                     MSG_LEN      = 20,
  parameter logic [8*MSG_LEN-1:0]   MSG          = "Hello Upduino VGA!  ",
  parameter int                     BAR_SHIFT    = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                eof_i,
  input  logic                start_i,
  input  test_mode_t          mode_i,
  video_test_gen_if.master    wr_if,
  output logic                busy_o,
  output logic                done_o
);

  localparam int N     = COLS * ROWS;
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] N_CNT   = CNT_W'(N);
  localparam logic [CNT_W-1:0] MSG_CNT = CNT_W'(MSG_LEN);
  localparam disp_addr_t LAST_ADDR = DISP_ADDR_W'(N - 1);
  localparam disp_addr_t LAST_COL  = DISP_ADDR_W'(COLS - 1);

  gen_state_t       state_q, state_d;
  test_mode_t       mode_q, mode_d;
  logic [CNT_W-1:0] beat_q, beat_d;      // beats loaded so far in this run
  disp_addr_t       pos_q, pos_d;        // next cell for screen-wide modes
  disp_addr_t       col_q, col_d;        // column of pos_q, for bars
  disp_addr_t       cursor_q, cursor_d;  // message cursor, persists across runs
  color_t           fcolor_q, fcolor_d;
  color_t           bcolor_q, bcolor_d;
  logic             wr_en_q, wr_en_d;
  disp_addr_t       wr_addr_q, wr_addr_d;
  disp_data_t       wr_data_q, wr_data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             delay_trig_s;
  logic             trig_s;
  logic             load_s;
  logic             last_s;
  logic [CNT_W-1:0] total_s;
  color_t           bar_s;

  video_test_delay #(.DELAY_FRAMES(DELAY_FRAMES)) u_delay (
    .clk    (clk),
    .reset  (reset),
    .eof_i  (eof_i),
    .trig_o (delay_trig_s)
  );

  assign trig_s = delay_trig_s | start_i;

  // Character k of the message, k = 0 being the leftmost.
  function automatic logic [7:0] msg_byte(input logic [CNT_W-1:0] k);
    logic [7:0] b;
    b = 8'h20;
    for (int i = 0; i < MSG_LEN; i++) begin
      if (k == CNT_W'(i)) b = MSG[8*(MSG_LEN-1-i) +: 8];
    end
    return b;
  endfunction

  // Next cell address; screen size need not be a power of two.
  function automatic disp_addr_t next_cell(input disp_addr_t a);
    return (a == LAST_ADDR) ? '0 : a + DISP_ADDR_W'(1);
  endfunction

  // Next-state and next-beat logic. A beat is loaded on RUN entry and on every
  // accepted beat except the last; source registers advance as each beat is loaded.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    beat_d    = beat_q;
    pos_d     = pos_q;
    col_d     = col_q;
    cursor_d  = cursor_q;
    fcolor_d  = fcolor_q;
    bcolor_d  = bcolor_q;
    wr_en_d   = wr_en_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    load_s    = 1'b0;
    last_s    = 1'b0;
    total_s   = (mode_q == TEST_MSG) ? MSG_CNT : N_CNT;
    bar_s     = color_t'(col_q >> BAR_SHIFT);

    case (state_q)
      IDLE: begin
        if (trig_s) begin
          state_d = RUN;
          mode_d  = mode_i;
          beat_d  = '0;
          pos_d   = '0;
          col_d   = '0;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        if (!wr_en_q) begin
          load_s = 1'b1;
        end else if (wr_if.wr_ready) begin
          if (beat_q == total_s) begin
            last_s = 1'b1;
          end else begin
            load_s = 1'b1;
          end
        end else begin
          load_s = 1'b0;
        end

        if (last_s) begin
          wr_en_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          state_d = RUN;
        end

        if (load_s) begin
          wr_en_d = 1'b1;
          beat_d  = beat_q + CNT_W'(1);
          case (mode_q)
            TEST_MSG: begin
              wr_addr_d = cursor_q;
              wr_data_d = pack_cell(bcolor_q, avoid_fore(fcolor_q, bcolor_q), msg_byte(beat_q));
              cursor_d  = next_cell(cursor_q);
              fcolor_d  = fcolor_q + 4'd1;
            end
            TEST_FILL: begin
              wr_addr_d = pos_q;
              wr_data_d = pack_cell(bcolor_q, avoid_fore(fcolor_q, bcolor_q), pos_q[7:0]);
              pos_d     = next_cell(pos_q);
            end
            TEST_CLEAR: begin
              wr_addr_d = pos_q;
              wr_data_d = 16'h0020;
              pos_d     = next_cell(pos_q);
            end
            TEST_BARS: begin
              // Bars carry fixed colours; the avoidance nudge applies only to
              // the rotating palette of message and fill.
              wr_addr_d = pos_q;
              wr_data_d = pack_cell(bar_s, 4'h0, 8'h20);
              pos_d     = next_cell(pos_q);
              col_d     = (col_q == LAST_COL) ? '0 : col_q + DISP_ADDR_W'(1);
            end
            default: begin
              wr_addr_d = '0;
              wr_data_d = '0;
            end
          endcase
        end else begin
          beat_d = beat_q;
        end
      end

      DONE: begin
        bcolor_d = bcolor_q + 4'd1;
        fcolor_d = bcolor_q + 4'd3;
        if (mode_q == TEST_CLEAR) begin
          cursor_d = '0;
        end else begin
          cursor_d = cursor_q;
        end
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any pattern in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      mode_q    <= TEST_MSG;
      beat_q    <= '0;
      pos_q     <= '0;
      col_q     <= '0;
      cursor_q  <= '0;
      fcolor_q  <= 4'd1;
      bcolor_q  <= 4'd0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      beat_q    <= beat_d;
      pos_q     <= pos_d;
      col_q     <= col_d;
      cursor_q  <= cursor_d;
      fcolor_q  <= fcolor_d;
      bcolor_q  <= bcolor_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign wr_if.wr_en   = wr_en_q;
  assign wr_if.wr_addr = wr_addr_q;
  assign wr_if.wr_data = wr_data_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;

endmodule

// File: tb/tb_video_test_gen.sv
// Scoreboard bench for video_test_gen on an 8x2 screen.
module tb_video_test_gen;
  import video_test_gen_pkg::*;

  localparam int COLS = 8;
  localparam int ROWS = 2;
  localparam int N    = COLS * ROWS;
  localparam int DF   = 3;
  localparam int ML   = 4;
  localparam int BS   = 2;

  typedef struct packed {
    logic [11:0] a;
    logic [15:0] d;
  } beat_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       eof, start, start2;
  test_mode_t mode;
  logic       busy, done, busy2, done2;

  video_test_gen_if vif ();
  video_test_gen_if vif2 ();

  video_test_gen #(.COLS(COLS), .ROWS(ROWS), .DELAY_FRAMES(DF), .MSG_LEN(ML),
                   .MSG("ABCD"), .BAR_SHIFT(BS)) dut (
    .clk(clk), .reset(reset), .eof_i(eof), .start_i(start), .mode_i(mode),
    .wr_if(vif), .busy_o(busy), .done_o(done));

  // Second instance with a 16-character message, long enough for fore to meet back.
  video_test_gen #(.COLS(COLS), .ROWS(ROWS), .DELAY_FRAMES(DF), .MSG_LEN(16),
                   .MSG("ABCDEFGHIJKLMNOP"), .BAR_SHIFT(BS)) dut2 (
    .clk(clk), .reset(reset), .eof_i(1'b0), .start_i(start2), .mode_i(TEST_MSG),
    .wr_if(vif2), .busy_o(busy2), .done_o(done2));

  always #5 clk = ~clk;

  beat_t      exp_q[$];
  beat_t      got_b;
  int         checks = 0, errors = 0;
  int         cyc = 0, last_acc_cyc = -10, done_cnt = 0, run_acc = 0, exp_beats = 0;
  int         ready_mode = 0;
  int         fc = 0, m_cursor = 0, m_f = 1, m_b = 0;
  logic [7:0] msg_b [ML] = '{8'h41, 8'h42, 8'h43, 8'h44};
  logic       prev_en = 1'b0, prev_rdy = 1'b0, prev_acc = 1'b0;
  logic [11:0] prev_addr = '0;
  logic [15:0] prev_data = '0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic int avoid_m(input int f, input int b);
    return (f == b) ? (f + 5) % 16 : f;
  endfunction

  task automatic push_beat(input int a, input int d);
    beat_t bt;
    bt.a = 12'(a);
    bt.d = 16'(d);
    exp_q.push_back(bt);
  endtask

  // Reference model: the beats a run must produce, from the pattern rules.
  task automatic model_run(input test_mode_t m);
    case (m)
      TEST_MSG: begin
        for (int k = 0; k < ML; k++) begin
          push_beat(m_cursor, m_b * 4096 + avoid_m(m_f, m_b) * 256 + int'(msg_b[k]));
          m_cursor = (m_cursor + 1) % N;
          m_f      = (m_f + 1) % 16;
        end
        exp_beats = ML;
      end
      TEST_FILL: begin
        for (int a = 0; a < N; a++) push_beat(a, m_b * 4096 + avoid_m(m_f, m_b) * 256 + a % 256);
        exp_beats = N;
      end
      TEST_CLEAR: begin
        for (int a = 0; a < N; a++) push_beat(a, 'h0020);
        m_cursor  = 0;
        exp_beats = N;
      end
      default: begin
        for (int a = 0; a < N; a++) push_beat(a, (((a % COLS) >> BS) % 16) * 4096 + 'h20);
        exp_beats = N;
      end
    endcase
    m_f = (m_b + 3) % 16;
    m_b = (m_b + 1) % 16;
  endtask

  task automatic start_run(input test_mode_t m);
    mode    = m;
    run_acc = 0;
    model_run(m);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic eof_pulse(output bit trig);
    eof = 1'b1;
    tick();
    eof = 1'b0;
    fc   = fc + 1;
    trig = 1'b0;
    if (fc == DF) begin
      fc   = 0;
      trig = 1'b1;
    end
  endtask

  task automatic eof_run(input test_mode_t m);
    bit t;
    mode    = m;
    run_acc = 0;
    t       = 1'b0;
    for (int i = 0; i < DF && !t; i++) begin
      eof_pulse(t);
      if (!t) tick();
    end
    model_run(m);
  endtask

  task automatic wait_done(input int budget);
    int d0 = done_cnt;
    int n  = 0;
    while (done_cnt == d0 && n < budget) begin
      tick();
      n++;
      if (busy) mode = test_mode_t'($urandom_range(0, 3));
    end
    chk("done_seen", int'(done_cnt > d0), 1);
    chk("beat_count", run_acc, exp_beats);
    chk("queue_empty", exp_q.size(), 0);
    tick();
    tick();
  endtask

  // Write-ready driver: always ready, 1,0,0,1 pattern, or random.
  initial begin
    int ph = 0;
    vif.wr_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        1:       vif.wr_ready = (ph % 4 == 0) || (ph % 4 == 3);
        2:       vif.wr_ready = 1'($urandom_range(0, 1));
        default: vif.wr_ready = 1'b1;
      endcase
      ph++;
    end
  end

  // Monitor: compares accepted beats with the scoreboard, checks stall hold,
  // back-to-back loading and done timing.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      prev_en  = 1'b0;
      prev_acc = 1'b0;
    end else begin
      if (prev_en && !prev_rdy) begin
        chk("stall_en", int'(vif.wr_en), 1);
        chk("stall_addr", int'(vif.wr_addr), int'(prev_addr));
        chk("stall_data", int'(vif.wr_data), int'(prev_data));
      end
      if (prev_acc && exp_q.size() > 0) chk("no_bubble", int'(vif.wr_en), 1);
      prev_acc = vif.wr_en && vif.wr_ready;
      if (prev_acc) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", int'(vif.wr_addr), -1);
        end else begin
          got_b = exp_q.pop_front();
          chk("beat_addr", int'(vif.wr_addr), int'(got_b.a));
          chk("beat_data", int'(vif.wr_data), int'(got_b.d));
        end
        last_acc_cyc = cyc;
        run_acc++;
      end
      if (done) begin
        done_cnt++;
        chk("done_timing", cyc, last_acc_cyc + 1);
      end
      prev_en   = vif.wr_en;
      prev_rdy  = vif.wr_ready;
      prev_addr = vif.wr_addr;
      prev_data = vif.wr_data;
    end
  end

  initial begin
    bit t;
    int d_before;
    int k;
    reset = 1'b1; eof = 1'b0; start = 1'b0; start2 = 1'b0; mode = TEST_MSG;
    vif2.wr_ready = 1'b1;
    tick();
    tick();
    chk("rst_wr_en", int'(vif.wr_en), 0);
    chk("rst_addr", int'(vif.wr_addr), 0);
    chk("rst_data", int'(vif.wr_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    reset = 1'b0;
    tick();

    // Frame delay: nothing after two frames, trigger two edges after the third.
    eof_pulse(t); tick();
    eof_pulse(t); tick(); tick(); tick();
    chk("no_early_trig", int'(busy), 0);
    mode    = TEST_MSG;
    run_acc = 0;
    eof_pulse(t);
    chk("trig_latency_a", int'(busy), 0);
    tick();
    chk("trig_latency_b", int'(busy), 1);
    model_run(TEST_MSG);
    wait_done(100);

    // Cursor and colour progression across runs, wrapping 15 -> 0.
    for (int r = 0; r < 4; r++) begin
      start_run(TEST_MSG);
      wait_done(100);
    end

    // Fill under a stalling consumer; a start while busy must be dropped.
    ready_mode = 1;
    start_run(TEST_FILL);
    tick(); tick(); tick();
    start = 1'b1; tick(); start = 1'b0;
    wait_done(300);
    d_before = done_cnt;
    repeat (20) tick();
    chk("single_done", done_cnt, d_before);
    chk("idle_after", int'(busy), 0);

    // Bars, clear, then a message restarting at cell 0.
    ready_mode = 0;
    start_run(TEST_BARS);  wait_done(100);
    start_run(TEST_CLEAR); wait_done(100);
    start_run(TEST_MSG);   wait_done(100);

    // Frame counter keeps running while busy; its wrap there is dropped.
    start_run(TEST_FILL);
    for (int i = 0; i < 4; i++) begin
      eof_pulse(t);
      tick();
    end
    wait_done(100);
    eof_run(TEST_MSG);
    wait_done(100);

    // Randomized runs.
    for (int r = 0; r < 12; r++) begin
      ready_mode = $urandom_range(0, 2);
      if ($urandom_range(0, 1) == 0) start_run(test_mode_t'($urandom_range(0, 3)));
      else eof_run(test_mode_t'($urandom_range(0, 3)));
      wait_done(400);
    end

    // Reset in the middle of a fill.
    ready_mode = 0;
    start_run(TEST_FILL);
    k = 0;
    while (run_acc < 5 && k < 50) begin
      tick();
      k++;
    end
    chk("mid_fill_reached", int'(run_acc >= 5), 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_wr_en", int'(vif.wr_en), 0);
    chk("mid_rst_addr", int'(vif.wr_addr), 0);
    chk("mid_rst_data", int'(vif.wr_data), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    exp_q.delete();
    m_cursor = 0; m_f = 1; m_b = 0; fc = 0;
    tick();
    reset = 1'b0;
    tick();
    start_run(TEST_MSG);
    wait_done(100);

    // Colour avoidance on the 16-character instance: beat 15 has fore == back == 0.
    start2 = 1'b1; tick(); start2 = 1'b0;
    k = 0;
    for (int c = 0; c < 60 && k < 16; c++) begin
      tick();
      if (vif2.wr_en) begin
        chk("avoid_addr", int'(vif2.wr_addr), k);
        chk("avoid_data", int'(vif2.wr_data), avoid_m((1 + k) % 16, 0) * 256 + 'h41 + k);
        k++;
      end
    end
    chk("avoid_beats", k, 16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
